// File: rtl/uart_mem_cmd_ctrl.sv
// UART command front end for a byte-wide memory: READ / WRITE / ERASE frames
// with address and length fields, answered with ACK or NAK over the tx handshake.
module uart_mem_cmd_ctrl #(
  parameter int         ADDR_WIDTH     = 12,
  parameter logic [7:0] FILL_BYTE      = 8'h00,
  parameter int         TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  input  logic                  tx_busy,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  input  logic [7:0]            mem_rdata,
  output logic                  busy,
  output logic                  err
);

  localparam int                  AB       = (ADDR_WIDTH + 7) / 8;
  localparam logic [1:0]          AB_LAST  = 2'(AB - 1);
  localparam logic [31:0]         TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] A_ONE  = ADDR_WIDTH'(1);
  localparam logic [7:0] CMD_READ = 8'h11, CMD_WRITE = 8'h12, CMD_ERASE = 8'h13;
  localparam logic [7:0] ESC = 8'h1B, ACK = 8'h06, NAK = 8'h15;

  typedef enum logic [3:0] {
    S_IDLE, S_GET_ADDR, S_GET_LEN, S_WR_DATA, S_RD_ISSUE,
    S_RD_WAIT, S_RD_SEND, S_TX_WAIT, S_ER_FILL, S_RESP
  } state_t;

  state_t                state_q, state_d;
  logic [7:0]            cmd_q, cmd_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, len_q, len_d, mem_addr_q, mem_addr_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [31:0]           tmo_q, tmo_d;
  logic                  seen_q, seen_d, last_q, last_d, nak_q, nak_d, err_q, err_d;
  logic                  tx_start_q, tx_start_d, mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [7:0]            tx_data_q, tx_data_d, mem_wdata_q, mem_wdata_d;
  logic                  timed_out;

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    tmo_d       = '0;
    seen_d      = seen_q;
    last_d      = last_q;
    nak_d       = nak_q;
    err_d       = err_q;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    timed_out   = (TIMEOUT_CYCLES != 0) && !rx_valid && (tmo_q == TMO_LAST);

    // Inter-byte idle counter only runs while a frame is being received.
    if (state_q == S_GET_ADDR || state_q == S_GET_LEN || state_q == S_WR_DATA)
      tmo_d = rx_valid ? '0 : tmo_q + 32'd1;

    case (state_q)
      S_IDLE: if (rx_valid) begin
        cnt_d = '0;
        if (rx_data == CMD_READ || rx_data == CMD_WRITE || rx_data == CMD_ERASE) begin
          cmd_d   = rx_data;
          err_d   = 1'b0;
          state_d = S_GET_ADDR;
        end else begin
          err_d   = 1'b1;
          nak_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_GET_ADDR: if (rx_valid) begin
        addr_d = (addr_q << 8) | ADDR_WIDTH'(rx_data);
        cnt_d  = cnt_q + 2'd1;
        if (cnt_q == AB_LAST) begin
          cnt_d   = '0;
          state_d = S_GET_LEN;
        end
      end else if (timed_out) begin
        err_d = 1'b1; nak_d = 1'b1; state_d = S_RESP;
      end
      S_GET_LEN: if (rx_valid) begin
        len_d = (len_q << 8) | ADDR_WIDTH'(rx_data);
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == AB_LAST) begin
          cnt_d = '0;
          if (cmd_q == CMD_WRITE)     state_d = S_WR_DATA;
          else if (cmd_q == CMD_READ) state_d = S_RD_ISSUE;
          else                        state_d = S_ER_FILL;
        end
      end else if (timed_out) begin
        err_d = 1'b1; nak_d = 1'b1; state_d = S_RESP;
      end
      S_WR_DATA: if (rx_valid) begin
        if (rx_data == ESC) begin
          err_d = 1'b1; nak_d = 1'b1; state_d = S_RESP;
        end else begin
          mem_en_d    = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = rx_data;
          addr_d      = addr_q + A_ONE;
          len_d       = len_q - A_ONE;
          if (len_q == '0) begin
            nak_d = 1'b0; state_d = S_RESP;
          end
        end
      end else if (timed_out) begin
        err_d = 1'b1; nak_d = 1'b1; state_d = S_RESP;
      end
      S_RD_ISSUE: begin
        mem_en_d   = 1'b1;
        mem_addr_d = addr_q;
        cnt_d      = '0;
        state_d    = S_RD_WAIT;
      end
      // Read data lands one cycle after the enable is seen by the memory.
      S_RD_WAIT: if (cnt_q == 2'd0) begin
        cnt_d = 2'd1;
      end else begin
        tx_data_d = mem_rdata;
        state_d   = S_RD_SEND;
      end
      S_RD_SEND: if (!tx_busy) begin
        tx_start_d = 1'b1; seen_d = 1'b0; last_d = 1'b0; state_d = S_TX_WAIT;
      end
      S_TX_WAIT: if (tx_busy) begin
        seen_d = 1'b1;
      end else if (seen_q) begin
        if (last_q) state_d = S_IDLE;
        else if (len_q == '0) begin
          nak_d = 1'b0; state_d = S_RESP;
        end else begin
          len_d = len_q - A_ONE; addr_d = addr_q + A_ONE; state_d = S_RD_ISSUE;
        end
      end
      S_ER_FILL: begin
        mem_en_d    = 1'b1;
        mem_we_d    = 1'b1;
        mem_addr_d  = addr_q;
        mem_wdata_d = FILL_BYTE;
        addr_d      = addr_q + A_ONE;
        len_d       = len_q - A_ONE;
        if (len_q == '0) begin
          nak_d = 1'b0; state_d = S_RESP;
        end
      end
      S_RESP: if (!tx_busy) begin
        tx_data_d  = nak_q ? NAK : ACK;
        tx_start_d = 1'b1; seen_d = 1'b0; last_d = 1'b1; state_d = S_TX_WAIT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cmd_q       <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      tmo_q       <= '0;
      seen_q      <= 1'b0;
      last_q      <= 1'b0;
      nak_q       <= 1'b0;
      err_q       <= 1'b0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      seen_q      <= seen_d;
      last_q      <= last_d;
      nak_q       <= nak_d;
      err_q       <= err_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign tx_start  = tx_start_q;
  assign tx_data   = tx_data_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != S_IDLE);
  assign err       = err_q;

endmodule

// File: tb/tb_uart_mem_cmd_ctrl.sv
// Scoreboarded bench: stimulus pushes expected writes / tx bytes from a
// reference model; monitors pop and compare as the DUT produces them.
module tb_uart_mem_cmd_ctrl;
  localparam int         AW    = 12;
  localparam int         DEPTH = 1 << AW;
  localparam logic [7:0] FILL  = 8'h5A;
  localparam int         TMO   = 100;
  localparam logic [7:0] ACK   = 8'h06, NAK = 8'h15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          tx_busy = 1'b0;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata = '0;
  logic          busy, err;

  always #5 clk = ~clk;

  uart_mem_cmd_ctrl #(.ADDR_WIDTH(AW), .FILL_BYTE(FILL), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .tx_busy(tx_busy),
    .tx_start(tx_start), .tx_data(tx_data), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .err(err)
  );

  typedef struct { logic [AW-1:0] a; logic [7:0] d; bit consec; } wr_t;
  wr_t        exp_wr[$];
  logic [7:0] exp_tx[$];
  logic [7:0] pay[$];
  logic [7:0] ref_mem [DEPTH];
  logic [7:0] ram [DEPTH];
  bit         ram_wr [DEPTH];
  int         checks = 0, errors = 0;
  int         cycle = 0, tx_count = 0, wr_count = 0;
  bit         exp_err = 1'b0;

  function automatic logic [7:0] init_val(input logic [AW-1:0] a);
    return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'h3C;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  always @(posedge clk) cycle <= cycle + 1;

  // Synchronous byte RAM: read data valid for exactly one cycle.
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      ram[mem_addr]    <= mem_wdata;
      ram_wr[mem_addr] <= 1'b1;
    end
    if (mem_en && !mem_we) mem_rdata <= ram_wr[mem_addr] ? ram[mem_addr] : init_val(mem_addr);
    else                   mem_rdata <= 8'hEE;
  end

  // UART transmitter model.
  initial begin
    logic [7:0] held;
    forever begin
      @(negedge clk);
      if (!rst && tx_start) begin
        held = tx_data;
        repeat ($urandom_range(0, 1)) @(negedge clk);
        #1 tx_busy = 1'b1;
        repeat ($urandom_range(1, 6)) begin
          @(negedge clk);
          chk("tx_data_held", 32'(tx_data), 32'(held));
        end
        #1 tx_busy = 1'b0;
      end
    end
  end

  // Output monitor / scoreboard.
  initial begin
    wr_t e;
    logic [7:0] b;
    bit prev_start;
    int last_wr;
    prev_start = 1'b0;
    last_wr = -10;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_start = 1'b0;
      end else begin
        if (mem_en && mem_we) begin
          if (exp_wr.size() == 0) begin
            chk("unexpected_write_addr", 32'(mem_addr), 32'hFFFF_FFFF);
          end else begin
            e = exp_wr.pop_front();
            chk("wr_addr", 32'(mem_addr), 32'(e.a));
            chk("wr_data", 32'(mem_wdata), 32'(e.d));
            if (e.consec) chk("wr_consecutive_gap", 32'(cycle - last_wr), 32'd1);
          end
          last_wr = cycle;
          wr_count++;
        end
        if (tx_start) begin
          chk("tx_start_while_busy", 32'(tx_busy), 32'd0);
          chk("tx_start_single_pulse", 32'(prev_start), 32'd0);
          if (exp_tx.size() == 0) begin
            chk("unexpected_tx_byte", 32'(tx_data), 32'hFFFF_FFFF);
          end else begin
            b = exp_tx.pop_front();
            chk("tx_byte", 32'(tx_data), 32'(b));
          end
          tx_count++;
        end
        prev_start = tx_start;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  // Upper nibble of the address MSB is junk that must be discarded.
  task automatic send_hdr(input logic [7:0] cmd, input logic [AW-1:0] a, input logic [AW-1:0] len);
    send_byte(cmd);
    send_byte({4'($urandom), a[11:8]});
    send_byte(a[7:0]);
    send_byte({4'h0, len[11:8]});
    send_byte(len[7:0]);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [AW-1:0] len);
    wr_t e;
    bit  aborted;
    aborted = 1'b0;
    for (int i = 0; i <= int'(len) && i < pay.size(); i++) begin
      if (pay[i] == 8'h1B) begin
        aborted = 1'b1;
        break;
      end
      e.a = AW'((int'(a) + i) % DEPTH);
      e.d = pay[i];
      e.consec = 1'b0;
      exp_wr.push_back(e);
      ref_mem[e.a] = pay[i];
    end
    exp_tx.push_back(aborted ? NAK : ACK);
    exp_err = aborted;
    send_hdr(8'h12, a, len);
    foreach (pay[i]) send_byte(pay[i]);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [AW-1:0] len, input bit spurious);
    for (int i = 0; i <= int'(len); i++) exp_tx.push_back(ref_mem[(int'(a) + i) % DEPTH]);
    exp_tx.push_back(ACK);
    exp_err = 1'b0;
    send_hdr(8'h11, a, len);
    if (spurious) begin
      repeat (3) @(negedge clk);
      rx_data = 8'h12; rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0; rx_data = 8'h00;
    end
  endtask

  task automatic do_erase(input logic [AW-1:0] a, input logic [AW-1:0] len);
    wr_t e;
    for (int i = 0; i <= int'(len); i++) begin
      e.a = AW'((int'(a) + i) % DEPTH);
      e.d = FILL;
      e.consec = (i > 0);
      exp_wr.push_back(e);
      ref_mem[e.a] = FILL;
    end
    exp_tx.push_back(ACK);
    exp_err = 1'b0;
    send_hdr(8'h13, a, len);
  endtask

  task automatic wait_idle(input string name, input bit check_err);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || exp_tx.size() != 0 || exp_wr.size() != 0) && n < 3000);
    chk({name, "_pending_tx"}, 32'(exp_tx.size()), 32'd0);
    chk({name, "_pending_wr"}, 32'(exp_wr.size()), 32'd0);
    chk({name, "_busy"}, 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    if (check_err) chk({name, "_err"}, 32'(err), 32'(exp_err));
    exp_tx.delete();
    exp_wr.delete();
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_tx_start"}, 32'(tx_start), 32'd0);
    chk({name, "_mem_en"}, 32'(mem_en), 32'd0);
    chk({name, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_err"}, 32'(err), 32'd0);
    chk({name, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({name, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    chk({name, "_tx_data"}, 32'(tx_data), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int            kind, start, n, abort_at, snap;
    logic [AW-1:0] ra, rl;
    logic [7:0]    b;
    wr_t           e;

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(AW'(i));

    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    pay = '{8'hAA, 8'hBB, 8'hCC};
    do_write(12'h010, 12'd2);
    wait_idle("write_basic", 1'b1);

    do_read(12'h010, 12'd2, 1'b1);
    wait_idle("read_back", 1'b1);

    do_erase(12'hFFE, 12'd3);
    wait_idle("erase_wrap", 1'b1);

    pay = '{8'h11, 8'h1B};
    do_write(12'h000, 12'd4);
    wait_idle("write_abort", 1'b1);

    exp_tx.push_back(NAK);
    send_byte(8'h42);
    wait_idle("illegal_cmd", 1'b0);

    // Header stalls after one address byte; NAK only after the idle limit.
    exp_tx.push_back(NAK);
    exp_err = 1'b1;
    snap = tx_count;
    send_byte(8'h11);
    send_byte(8'h00);
    repeat (TMO - 10) @(negedge clk);
    chk("timeout_not_early", 32'(tx_count - snap), 32'd0);
    wait_idle("timeout", 1'b1);

    // Reset while the third fill write is on the bus.
    start = wr_count;
    for (int i = 0; i < 3; i++) begin
      e.a = AW'(12'h100 + i);
      e.d = FILL;
      e.consec = (i > 0);
      exp_wr.push_back(e);
    end
    ref_mem[12'h100] = FILL;
    ref_mem[12'h101] = FILL;
    send_hdr(8'h13, 12'h100, 12'd9);
    n = 0;
    do begin
      @(negedge clk);
      #1 n++;
    end while (wr_count < start + 3 && n < 200);
    chk("erase_third_write_seen", 32'(wr_count - start), 32'd3);
    rst = 1'b1;
    #1;
    chk_reset_outputs("midframe_reset");
    repeat (3) @(negedge clk);
    chk_reset_outputs("held_reset");
    rst = 1'b0;
    exp_err = 1'b0;
    wait_idle("after_reset", 1'b1);
    chk("no_tx_after_reset", 32'(tx_count), 32'(snap + 1));

    pay = '{8'h01, 8'h02};
    do_write(12'h100, 12'd1);
    wait_idle("recover_write", 1'b1);
    do_read(12'h0FF, 12'd4, 1'b0);
    wait_idle("recover_read", 1'b1);

    for (int f = 0; f < 40; f++) begin
      kind = $urandom_range(0, 9);
      ra   = AW'($urandom);
      rl   = AW'($urandom_range(0, 5));
      if (kind == 0) begin
        b = 8'($urandom);
        if (b == 8'h11 || b == 8'h12 || b == 8'h13) b = 8'h42;
        exp_tx.push_back(NAK);
        send_byte(b);
        wait_idle("rand_illegal", 1'b0);
      end else if (kind <= 3) begin
        do_read(ra, rl, 1'b0);
        wait_idle("rand_read", 1'b1);
      end else if (kind <= 6) begin
        pay.delete();
        abort_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, int'(rl))) : -1;
        for (int i = 0; i <= int'(rl); i++) begin
          if (i == abort_at) begin
            pay.push_back(8'h1B);
            break;
          end
          b = 8'($urandom);
          if (b == 8'h1B) b = 8'h1C;
          pay.push_back(b);
        end
        do_write(ra, rl);
        wait_idle("rand_write", 1'b1);
      end else begin
        do_erase(ra, rl);
        wait_idle("rand_erase", 1'b1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_mem_cmd_ctrl.md
UART_MEM_CMD_CTRL -- requirements
Module: uart_mem_cmd_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 12, memory address width; legal range 8..24.
REQ-002 Parameter FILL_BYTE, default 8'h00, value written by ERASE.
REQ-003 Parameter TIMEOUT_CYCLES, default 1000000, maximum idle clk cycles between received bytes of one command; 0 disables the timeout.
REQ-004 Derived constant AB = ceil(ADDR_WIDTH/8), the number of address or length bytes per field.
REQ-005 clk  in  1  clock; all logic is rising-edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 rx_data  in  8  received UART byte; valid only while rx_valid=1.
REQ-008 rx_valid  in  1  single-cycle strobe, one per received byte.
REQ-009 tx_busy  in  1  transmitter busy; rises at most 2 cycles after tx_start.
REQ-010 tx_start  out  1  single-cycle transmit request.
REQ-011 tx_data  out  8  byte to transmit; held stable from tx_start until tx_busy falls.
REQ-012 mem_en, mem_we  out  1 each  memory enable and write enable.
REQ-013 mem_addr  out  ADDR_WIDTH  memory address.
REQ-014 mem_wdata  out  8  memory write data.
REQ-015 mem_rdata  in  8  memory read data, valid exactly 1 cycle after mem_en=1 with mem_we=0.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 err  out  1  sticky error flag; cleared by the next valid command byte.

Function
REQ-018 Frame format: CMD byte, then AB address bytes (MSB first), then AB length bytes (MSB first); length field L selects L+1 bytes; WRITE frames then carry L+1 data bytes.
REQ-019 Commands: 8'h11 READ, 8'h12 WRITE, 8'h13 ERASE; any other byte in IDLE -> NAK.
REQ-020 States: IDLE, GET_ADDR, GET_LEN, WR_DATA, RD_ISSUE, RD_WAIT, RD_SEND, TX_WAIT, ER_FILL, RESP.
REQ-021 IDLE -> GET_ADDR on rx_valid with a legal command; the command is latched.
REQ-022 GET_ADDR and GET_LEN shift in one byte per rx_valid; after AB bytes each advances; GET_LEN exits to WR_DATA, RD_ISSUE or ER_FILL according to the latched command.
REQ-023 Address bits above ADDR_WIDTH are discarded; the length counter is ADDR_WIDTH bits wide.
REQ-024 The address increments by 1 per transferred byte and wraps modulo 2^ADDR_WIDTH with no error.
REQ-025 WR_DATA: each rx_valid drives mem_en=1 and mem_we=1 for exactly one cycle, with mem_wdata=rx_data and mem_addr equal to the current address.
REQ-026 WR_DATA: rx_data=8'h1B aborts the frame; that byte is not written, err is set, and a NAK is sent.
REQ-027 READ: RD_ISSUE pulses mem_en for 1 cycle; RD_WAIT captures mem_rdata into tx_data; RD_SEND pulses tx_start when tx_busy=0; TX_WAIT waits until tx_busy has been seen high and then low; the next byte is issued, or RESP is entered after the L+1th byte.
REQ-028 ERASE: writes FILL_BYTE to one address per cycle, L+1 consecutive cycles, with mem_en=mem_we=1 throughout.
REQ-029 RESP: transmits 8'h06 (ACK) on success or 8'h15 (NAK) on error using the tx handshake in REQ-027, then returns to IDLE.
REQ-030 Timeout: in GET_ADDR, GET_LEN or WR_DATA, TIMEOUT_CYCLES cycles without rx_valid -> err=1, NAK, IDLE.
REQ-031 An rx_valid arriving in any state other than IDLE, GET_ADDR, GET_LEN or WR_DATA is ignored.
REQ-032 tx_start is never asserted while tx_busy=1; mem_we is never asserted outside WR_DATA and ER_FILL.

Reset
REQ-033 While rst=1: state=IDLE; tx_start, mem_en, mem_we, busy and err are 0; mem_addr, mem_wdata and tx_data are 0.
REQ-034 Reset asserted mid-frame abandons the frame immediately; no further memory write and no response byte follow.

Verification (ADDR_WIDTH=12, AB=2)
REQ-035 Send 12 00 10 00 02 AA BB CC -> writes AA, BB, CC to addresses 0x010..0x012, then ACK 0x06.
REQ-036 After REQ-035, send 11 00 10 00 02 -> tx bytes AA, BB, CC, 06; there is exactly 1 tx_start per tx_busy cycle.
REQ-037 Send 13 0F FE 00 03 -> FILL_BYTE is written to 0xFFE, 0xFFF, 0x000, 0x001 (wrap-around) on 4 consecutive cycles, then ACK.
REQ-038 Send 12 00 00 00 04 11 1B -> only 0x000=11 is written; err=1; NAK 0x15.
REQ-039 Send byte 0x42 in IDLE -> NAK; separately, with TIMEOUT_CYCLES=100, send 11 00 then wait 100 cycles -> NAK and err=1.
REQ-040 Assert rst during the third data byte of an ERASE -> mem_we=0 in the same cycle, all outputs reach reset values, and the next frame completes normally.
